// File: rtl/nrzi_pkg.sv
// Shared types and sizing helpers for the NRZI bit-stuffing codec.
package nrzi_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  // Width of a counter that has to hold 0..stuff_len inclusive.
  function automatic int run_cnt_width(input int stuff_len);
    return $clog2(stuff_len + 1);
  endfunction

endpackage

// File: rtl/nrzi_stuff_codec_if.sv
// Serial bit stream handshake between the packet engine side and the codec.
interface nrzi_stuff_codec_if;
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_bit;
  logic out_stuff;
  logic stuff_err;

  modport master (
    output in_valid, in_bit,
    input  in_ready, out_valid, out_bit, out_stuff, stuff_err
  );

  modport slave (
    input  in_valid, in_bit,
    output in_ready, out_valid, out_bit, out_stuff, stuff_err
  );
endinterface

// File: rtl/nrzi_run_counter.sv
// Counts consecutive data 1s, saturating at STUFF_LEN; flags when the limit is reached.
module nrzi_run_counter
  import nrzi_pkg::*;
#(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic zero,
  output logic at_limit
);

  localparam int CNT_W = run_cnt_width(STUFF_LEN);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUFF_LEN);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (clr || zero) begin
      run_cnt_d = '0;
    end else if (inc && (run_cnt_q != LIMIT)) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign at_limit = (run_cnt_q == LIMIT);

endmodule

// File: rtl/nrzi_stuff_codec.sv
// NRZI line codec (toggle on 0, hold on 1) with run-length bit stuffing; MODE picks direction.
module nrzi_stuff_codec
  import nrzi_pkg::*;
#(
  parameter mode_t MODE       = MODE_ENC,
  parameter int    STUFF_LEN  = 6,
  parameter logic  IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic stuff_en,
  nrzi_stuff_codec_if.slave io
);

  // Encoder idles at the line level; decoder output is data and idles at 0.
  localparam logic OUT_RST = (MODE == MODE_ENC) ? IDLE_LEVEL : 1'b0;

  logic level_q,     level_d;
  logic out_valid_q, out_valid_d;
  logic out_bit_q,   out_bit_d;
  logic out_stuff_q, out_stuff_d;
  logic stuff_err_q, stuff_err_d;
  logic cnt_inc, cnt_zero, at_limit;
  logic stuff_pos, decoded;

  nrzi_run_counter #(.STUFF_LEN(STUFF_LEN)) u_run_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (cnt_inc),
    .zero     (cnt_zero),
    .at_limit (at_limit)
  );

  assign stuff_pos   = stuff_en && at_limit;
  assign decoded     = (io.in_bit == level_q);
  assign io.in_ready = (MODE == MODE_ENC) ? !stuff_pos : 1'b1;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    level_d     = level_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    out_stuff_d = 1'b0;
    stuff_err_d = 1'b0;
    cnt_inc     = 1'b0;
    cnt_zero    = 1'b0;

    if (clr) begin
      level_d   = IDLE_LEVEL;
      out_bit_d = OUT_RST;
    end else if (MODE == MODE_ENC) begin
      // A stuff cycle pre-empts any offered data bit, which stays pending.
      if (stuff_pos) begin
        level_d     = !level_q;
        cnt_zero    = 1'b1;
        out_valid_d = 1'b1;
        out_bit_d   = !level_q;
        out_stuff_d = 1'b1;
      end else if (io.in_valid) begin
        level_d     = io.in_bit ? level_q : !level_q;
        cnt_inc     = io.in_bit;
        cnt_zero    = !io.in_bit;
        out_valid_d = 1'b1;
        out_bit_d   = level_d;
      end
    end else if (io.in_valid) begin
      level_d  = io.in_bit;
      cnt_zero = stuff_pos || !decoded;
      cnt_inc  = !stuff_pos && decoded;
      if (stuff_pos) begin
        // The stuffed bit is always dropped; a missing transition there is a line error.
        stuff_err_d = decoded;
      end else begin
        out_valid_d = 1'b1;
        out_bit_d   = decoded;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= IDLE_LEVEL;
      out_valid_q <= 1'b0;
      out_bit_q   <= OUT_RST;
      out_stuff_q <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_stuff_q <= out_stuff_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_bit   = out_bit_q;
  assign io.out_stuff = out_stuff_q;
  assign io.stuff_err = stuff_err_q;

endmodule

// File: tb/tb_nrzi_stuff_codec.sv
// Directed scoreboard bench: one encoder and one decoder instance, STUFF_LEN=6, IDLE_LEVEL=1.
module tb_nrzi_stuff_codec;
  import nrzi_pkg::*;

  typedef struct {
    logic err;
    logic b;
    logic stf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_clr = 1'b0, enc_stuff_en = 1'b0;
  logic dec_clr = 1'b0, dec_stuff_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int enc_stall = 0;

  exp_t enc_q[$];
  exp_t dec_q[$];

  nrzi_stuff_codec_if enc_if ();
  nrzi_stuff_codec_if dec_if ();

  nrzi_stuff_codec #(.MODE(MODE_ENC), .STUFF_LEN(6), .IDLE_LEVEL(1'b1)) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (enc_clr),
    .stuff_en (enc_stuff_en),
    .io       (enc_if)
  );

  nrzi_stuff_codec #(.MODE(MODE_DEC), .STUFF_LEN(6), .IDLE_LEVEL(1'b1)) u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (dec_clr),
    .stuff_en (dec_stuff_en),
    .io       (dec_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic b, input logic stf);
    exp_t e;
    e.err = err;
    e.b   = b;
    e.stf = stf;
    return e;
  endfunction

  task automatic push_enc(input logic b, input logic stf);
    enc_q.push_back(mk(1'b0, b, stf));
  endtask

  task automatic push_dec(input logic err, input logic b);
    dec_q.push_back(mk(err, b, 1'b0));
  endtask

  // Offer a bit at the negedge and hold it until the encoder takes it.
  task automatic enc_send(input logic b);
    int n;
    n = 0;
    enc_if.in_valid = 1'b1;
    enc_if.in_bit   = b;
    #1;
    while (!enc_if.in_ready && n <= 8) begin
      enc_stall++;
      n++;
      @(negedge clk);
      #1;
    end
    if (n > 8) check("enc_send_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic enc_idle();
    enc_if.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic dec_send(input logic b);
    dec_if.in_valid = 1'b1;
    dec_if.in_bit   = b;
    @(negedge clk);
  endtask

  // Encoder monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (enc_if.out_valid === 1'b1) begin
        check("enc_output_expected", int'(enc_q.size() > 0), 1);
        if (enc_q.size() > 0) begin
          e = enc_q.pop_front();
          check("enc_out_bit", int'(enc_if.out_bit), int'(e.b));
          check("enc_out_stuff", int'(enc_if.out_stuff), int'(e.stf));
        end
      end
    end
  end

  // Decoder monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dec_if.out_valid === 1'b1 || dec_if.stuff_err === 1'b1) begin
        check("dec_output_expected", int'(dec_q.size() > 0), 1);
        if (dec_q.size() > 0) begin
          e = dec_q.pop_front();
          check("dec_stuff_err", int'(dec_if.stuff_err), int'(e.err));
          check("dec_out_valid", int'(dec_if.out_valid), int'(!e.err));
          if (!e.err) check("dec_out_bit", int'(dec_if.out_bit), int'(e.b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin
    enc_if.in_valid = 1'b0;
    enc_if.in_bit   = 1'b0;
    dec_if.in_valid = 1'b0;
    dec_if.in_bit   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enc_stuff_en = 1'b1;
    dec_stuff_en = 1'b1;
    #1;
    check("rst_enc_out_valid", int'(enc_if.out_valid), 0);
    check("rst_enc_out_bit", int'(enc_if.out_bit), 1);
    check("rst_enc_out_stuff", int'(enc_if.out_stuff), 0);
    check("rst_enc_in_ready", int'(enc_if.in_ready), 1);
    check("rst_dec_out_valid", int'(dec_if.out_valid), 0);
    check("rst_dec_out_bit", int'(dec_if.out_bit), 0);
    check("rst_dec_stuff_err", int'(dec_if.stuff_err), 0);
    check("rst_dec_in_ready", int'(dec_if.in_ready), 1);
    @(negedge clk);

    // Encoder: 0,0,1,0 from idle level 1
    push_enc(0, 0); push_enc(1, 0); push_enc(1, 0); push_enc(0, 0);
    enc_send(0); enc_send(0); enc_send(1); enc_send(0);
    enc_idle();

    // Encoder: eight 1s with stuffing, one stall cycle
    enc_clr = 1'b1; @(negedge clk); enc_clr = 1'b0;
    for (int i = 0; i < 6; i++) push_enc(1, 0);
    push_enc(0, 1); push_enc(0, 0); push_enc(0, 0);
    enc_stall = 0;
    for (int i = 0; i < 8; i++) enc_send(1);
    enc_idle();
    check("enc_stall_cycles_stuff_on", enc_stall, 1);

    // Encoder: stuffing disabled, then enabled on a saturated counter
    enc_stuff_en = 1'b0;
    enc_clr = 1'b1; @(negedge clk); enc_clr = 1'b0;
    for (int i = 0; i < 8; i++) push_enc(1, 0);
    enc_stall = 0;
    for (int i = 0; i < 8; i++) enc_send(1);
    enc_if.in_valid = 1'b0;
    check("enc_stall_cycles_stuff_off", enc_stall, 0);
    push_enc(0, 1);
    enc_stuff_en = 1'b1;
    #1;
    check("enc_ready_low_on_late_stuff_en", int'(enc_if.in_ready), 0);
    @(negedge clk);
    #1;
    check("enc_ready_after_late_stuff", int'(enc_if.in_ready), 1);
    @(negedge clk);

    // Decoder: 1x6, stuffed transition dropped, then a held line decodes to 1
    for (int i = 0; i < 7; i++) push_dec(0, 1);
    for (int i = 0; i < 6; i++) dec_send(1);
    dec_send(0); dec_send(0);
    dec_if.in_valid = 1'b0;
    @(negedge clk);

    // Decoder: seven 1s, missing transition flags an error, then 0 decodes to 0
    dec_clr = 1'b1; @(negedge clk); dec_clr = 1'b0;
    for (int i = 0; i < 6; i++) push_dec(0, 1);
    push_dec(1, 0);
    push_dec(0, 0);
    for (int i = 0; i < 7; i++) dec_send(1);
    dec_send(0);
    dec_if.in_valid = 1'b0;
    @(negedge clk);

    // Encoder: clr mid-run (run 4, level 0) then async reset between edges
    enc_clr = 1'b1; @(negedge clk); enc_clr = 1'b0;
    for (int i = 0; i < 5; i++) push_enc(0, 0);
    enc_send(0);
    for (int i = 0; i < 4; i++) enc_send(1);
    enc_if.in_valid = 1'b1;
    enc_if.in_bit   = 1'b0;
    enc_clr = 1'b1;
    @(negedge clk);
    enc_clr = 1'b0;
    #1;
    check("clr_enc_out_valid", int'(enc_if.out_valid), 0);
    check("clr_enc_out_bit", int'(enc_if.out_bit), 1);
    for (int i = 0; i < 6; i++) push_enc(1, 0);
    push_enc(0, 1);
    for (int i = 0; i < 6; i++) enc_send(1);
    enc_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_enc_out_bit", int'(enc_if.out_bit), 1);
    check("async_rst_enc_out_valid", int'(enc_if.out_valid), 0);
    check("async_rst_enc_out_stuff", int'(enc_if.out_stuff), 0);
    check("async_rst_dec_out_bit", int'(dec_if.out_bit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("enc_queue_drained", enc_q.size(), 0);
    check("dec_queue_drained", dec_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nrzi_stuff_codec.md
Name: nrzi_stuff_codec

Overview:
Parametrised NRZI line codec with bit stuffing, successor to the single-bit toggle-on-zero converter.
- MODE selects encoder (data to line) or decoder (line to data). Both use the same rule: the line toggles on a 0 and holds on a 1.
- Adds run-length bit stuffing, a valid/ready input handshake, a stuff-error flag and a synchronous clear.
- Sits between the serial packet engine and the line I/O pads.

Parameters:
MODE, MODE_ENC, codec direction (nrzi_pkg::mode_t: MODE_ENC or MODE_DEC)
STUFF_LEN, 6, consecutive data 1s after which a 0 is stuffed (encoder) or removed (decoder); legal range 2..15
IDLE_LEVEL, 1'b1, line level after reset or clr

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear between packets
stuff_en  input  1  enables stuff insertion/removal
in_valid  input  1  in_bit is valid this cycle
in_ready  output  1  codec accepts in_bit this cycle
in_bit  input  1  encoder: data bit; decoder: line bit
out_valid  output  1  out_bit is valid (registered)
out_bit  output  1  encoder: line level; decoder: data bit
out_stuff  output  1  encoder: out_bit is a stuffed bit (registered)
stuff_err  output  1  decoder: stuff position carried no transition (1-cycle pulse)

Behaviour:
Reset and clear
- Reset values: level reg = IDLE_LEVEL; run_cnt = 0; out_valid = 0; out_bit = IDLE_LEVEL in encoder mode, 0 in decoder mode; out_stuff = 0; stuff_err = 0.
- Reset is asynchronous and active-low. Asserting it mid-stream aborts immediately; no partial state survives.
- clr (synchronous) restores the same values on the next edge and has priority over in_valid. in_bit is ignored in a clr cycle.

Run counter
- run_cnt counts consecutive data 1s, clears on a data 0, and saturates at STUFF_LEN.
- run_cnt width = $clog2(STUFF_LEN+1).

Encoder (MODE_ENC)
- in_ready = !(stuff_en && run_cnt == STUFF_LEN), combinational.
- Accept (in_valid && in_ready):
  - bit 0: level toggles, run_cnt <= 0.
  - bit 1: level holds, run_cnt increments.
  - Next edge: out_valid = 1, out_bit = new level. Latency 1 cycle.
- Stuff cycle (stuff_en && run_cnt == STUFF_LEN), independent of in_valid:
  - level toggles, run_cnt <= 0.
  - out_valid = 1, out_stuff = 1.
  - in_ready = 0 for exactly this one cycle.
- No accept and no stuff: out_valid = 0, level holds.

Decoder (MODE_DEC)
- in_ready is tied to 1.
- On in_valid: decoded = (in_bit == level) ? 1 : 0; then level <= in_bit.
- Stuff position (stuff_en && run_cnt == STUFF_LEN):
  - decoded 0: bit dropped (out_valid = 0), run_cnt <= 0.
  - decoded 1: bit dropped, stuff_err pulses 1 cycle, run_cnt <= 0.
- Otherwise: out_valid = 1, out_bit = decoded, run_cnt updated as above. Latency 1 cycle.

stuff_en behaviour
- stuff_en = 0: no insertion or removal; the counter still tracks and saturates.
- Raising stuff_en while run_cnt == STUFF_LEN triggers the stuff action on that same cycle.

Decomposition:
- nrzi_pkg holds the mode_t enum {MODE_ENC, MODE_DEC} and the function/constant for the run counter width.
- One sub-module, nrzi_run_counter (parameter STUFF_LEN):
  - inputs: clr, inc, zero
  - output: at_limit
  - shared by both modes.
- The codec top contains the level register, the mode-selected next-state/output logic and the output registers.

Test Plan:
1. ENC, stuff_en=1, data 0,0,1,0 on consecutive cycles after reset → out_bit 0,1,1,0 with out_valid=1, each 1 cycle after its input.
2. ENC, stuff_en=1, eight 1s from level 1 → six out_bit=1, then stuffed out_bit=0 with out_stuff=1 and in_ready=0 for that cycle, then two out_bit=0. Total 9 valid outputs.
3. DEC, stuff_en=1, line bits 1,1,1,1,1,1,0,0 from level 1 → out_bit 1×6, stuffed bit dropped (out_valid=0 for one cycle), then out_bit=1. No stuff_err.
4. DEC, stuff_en=1, line bits 1×7 → six out_bit=1, seventh dropped with stuff_err=1 for one cycle; next line 0 decodes to 0.
5. ENC, stuff_en=0, eight 1s → eight out_bit=1, in_ready stays 1, out_stuff stays 0. Raising stuff_en afterwards produces one stuff cycle immediately.
6. clr asserted mid-run (run_cnt=4, level=0) → next cycle level=1, run_cnt=0, out_valid=0. Asserting rst_n=0 between edges forces out_bit to IDLE_LEVEL without waiting for a clock edge.
